// File: rtl/serial_bus_pkg.sv
// Shared types and defaults for the serial bus memory slaves: FSM state
// encoding, default widths and the even-parity helper.
package serial_bus_pkg;

  localparam int unsigned SB_DATA_W   = 8;
  localparam int unsigned SB_ADDR_W   = 12;
  localparam int unsigned SB_ID_W     = 1;
  localparam int unsigned SB_SLAVE_ID = 0;
  localparam int unsigned SB_LEN_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    DROP,
    RFETCH,
    RDATA
  } sb_state_e;

  // Even parity bit: makes the XOR over data plus parity equal zero.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_bram.sv
// Single-port block RAM with synchronous read (one-cycle latency, read-first).
module serial_bram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOC_W  = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LOC_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << LOC_W) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/serial_burst_slave.sv
// Bit-serial burst bus slave with internal BRAM, ID window decode and
// address auto-increment. Define SERIAL_PARITY_EN to add per-beat even parity.
module serial_burst_slave
  import serial_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = SB_DATA_W,
  parameter int unsigned ADDR_W   = SB_ADDR_W,
  parameter int unsigned ID_W     = SB_ID_W,
  parameter int unsigned SLAVE_ID = SB_SLAVE_ID,
  parameter int unsigned LEN_W    = SB_LEN_W
) (
  input  logic clk,
  input  logic rst,
  input  logic validIn,
  input  logic wren,
  input  logic Address,
  input  logic DataIn,
  output logic ready,
  output logic validOut,
  output logic DataOut,
  output logic wr_done
`ifdef SERIAL_PARITY_EN
  ,
  output logic perr
`endif
);

  localparam int unsigned LOC_W = ADDR_W - ID_W;
  localparam int unsigned HDR_W = ADDR_W + LEN_W;
  localparam int unsigned HC_W  = $clog2(HDR_W + 1);
`ifdef SERIAL_PARITY_EN
  localparam int unsigned BITS  = DATA_W + 1;
`else
  localparam int unsigned BITS  = DATA_W;
`endif
  localparam int unsigned BC_W  = $clog2(BITS + 1);

  sb_state_e         state;
  logic [HC_W-1:0]   hdr_cnt;
  logic [HDR_W-2:0]  hdr_sr;
  logic              is_wr;
  logic [LOC_W-1:0]  loc_addr;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [BITS-2:0]   wr_sr;
  logic              wr_fin;
  logic [DATA_W-1:0] rd_sr;
  logic              rd_par;
  logic              mem_we;
  logic [LOC_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;

  logic [HDR_W-1:0]  hdr_next_c;
  logic [ID_W-1:0]   hdr_id_c;
  logic [LOC_W-1:0]  hdr_loc_c;
  logic [LEN_W-1:0]  hdr_len_c;
  logic              hit_c;
  logic [BITS-1:0]   wr_next_c;
  logic [DATA_W-1:0] wr_word_c;
  logic              wr_ok_c;
  logic [LOC_W-1:0]  raddr_c;
  logic [LOC_W-1:0]  bram_addr_c;

  // Header/data word as it looks once the bit on the wire is shifted in.
  assign hdr_next_c = {hdr_sr, Address};
  assign hdr_id_c   = hdr_next_c[HDR_W-1 -: ID_W];
  assign hdr_loc_c  = hdr_next_c[LEN_W +: LOC_W];
  assign hdr_len_c  = hdr_next_c[LEN_W-1:0];
  assign hit_c      = (hdr_id_c == ID_W'(SLAVE_ID));
  assign wr_next_c  = {wr_sr, DataIn};

`ifdef SERIAL_PARITY_EN
  assign wr_word_c = wr_next_c[DATA_W:1];
  assign wr_ok_c   = (even_par(64'(wr_word_c)) == wr_next_c[0]);
`else
  assign wr_word_c = wr_next_c;
  assign wr_ok_c   = 1'b1;
`endif

  // Read address runs one step ahead so RFETCH already sees the BRAM output.
  always_comb begin
    raddr_c = loc_addr;
    case (state)
      HDR:     raddr_c = hdr_loc_c;
      RDATA:   raddr_c = loc_addr + 1'b1;
      default: raddr_c = loc_addr;
    endcase
  end

  assign bram_addr_c = mem_we ? mem_waddr : raddr_c;

  serial_bram #(
    .DATA_W (DATA_W),
    .LOC_W  (LOC_W)
  ) u_bram (
    .clk   (clk),
    .we    (mem_we & ~rst),
    .addr  (bram_addr_c),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      validOut  <= 1'b0;
      DataOut   <= 1'b0;
      wr_done   <= 1'b0;
      hdr_cnt   <= '0;
      hdr_sr    <= '0;
      is_wr     <= 1'b0;
      loc_addr  <= '0;
      len_r     <= '0;
      beat_cnt  <= '0;
      bit_cnt   <= '0;
      wr_sr     <= '0;
      wr_fin    <= 1'b0;
      rd_sr     <= '0;
      rd_par    <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
`ifdef SERIAL_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      mem_we  <= 1'b0;
      wr_done <= 1'b0;
`ifdef SERIAL_PARITY_EN
      perr    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (validIn) begin
            is_wr   <= wren;
            hdr_sr  <= hdr_next_c[HDR_W-2:0];
            hdr_cnt <= HC_W'(1);
            ready   <= 1'b0;
            state   <= HDR;
          end
        end
        HDR: begin
          if (validIn) begin
            hdr_sr  <= hdr_next_c[HDR_W-2:0];
            hdr_cnt <= hdr_cnt + 1'b1;
            if (hdr_cnt == HC_W'(HDR_W - 1)) begin
              hdr_cnt  <= '0;
              len_r    <= hdr_len_c;
              loc_addr <= hdr_loc_c;
              beat_cnt <= '0;
              bit_cnt  <= '0;
              if (hit_c)      state <= is_wr ? WDATA : RFETCH;
              else if (is_wr) state <= DROP;
              else begin
                state <= IDLE;
                ready <= 1'b1;
              end
            end
          end
        end
        WDATA: begin
          if (wr_fin) begin
            wr_fin  <= 1'b0;
            wr_done <= 1'b1;
            ready   <= 1'b1;
            state   <= IDLE;
          end else if (validIn) begin
            if (bit_cnt == BC_W'(BITS - 1)) begin
              // Beat complete: commit next cycle, advance address now.
              mem_we    <= wr_ok_c;
              mem_waddr <= loc_addr;
              mem_wdata <= wr_word_c;
              loc_addr  <= loc_addr + 1'b1;
              bit_cnt   <= '0;
`ifdef SERIAL_PARITY_EN
              perr      <= ~wr_ok_c;
`endif
              if (beat_cnt == len_r) wr_fin <= 1'b1;
              else                   beat_cnt <= beat_cnt + 1'b1;
            end else begin
              wr_sr   <= wr_next_c[BITS-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (validIn) begin
            if (bit_cnt == BC_W'(BITS - 1)) begin
              bit_cnt <= '0;
              if (beat_cnt == len_r) begin
                state <= IDLE;
                ready <= 1'b1;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RFETCH: begin
          rd_sr    <= {rdata[DATA_W-2:0], 1'b0};
          rd_par   <= even_par(64'(rdata));
          DataOut  <= rdata[DATA_W-1];
          validOut <= 1'b1;
          bit_cnt  <= '0;
          state    <= RDATA;
        end
        RDATA: begin
          if (bit_cnt == BC_W'(BITS - 1)) begin
            validOut <= 1'b0;
            DataOut  <= 1'b0;
            bit_cnt  <= '0;
            loc_addr <= loc_addr + 1'b1;
            if (beat_cnt == len_r) begin
              state <= IDLE;
              ready <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              state    <= RFETCH;
            end
          end else begin
            DataOut <= (bit_cnt == BC_W'(DATA_W - 1)) ? rd_par : rd_sr[DATA_W-1];
            rd_sr   <= {rd_sr[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed bench for serial_burst_slave: single/burst writes and reads,
// address wrap, ID miss, validIn stalls, reset mid-frame and optional parity.
module tb_serial_burst_slave;

`ifdef SERIAL_PARITY_EN
  localparam int BITS = 9;
`else
  localparam int BITS = 8;
`endif

  logic clk = 1'b0;
  logic rst, validIn, wren, Address, DataIn;
  logic ready, validOut, DataOut, wr_done;
`ifdef SERIAL_PARITY_EN
  logic perr;
`endif

  serial_burst_slave dut (
    .clk      (clk),
    .rst      (rst),
    .validIn  (validIn),
    .wren     (wren),
    .Address  (Address),
    .DataIn   (DataIn),
    .ready    (ready),
    .validOut (validOut),
    .DataOut  (DataOut),
    .wr_done  (wr_done)
`ifdef SERIAL_PARITY_EN
    ,
    .perr     (perr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_done_cnt = 0;
  int perr_cnt = 0;
  bit cap = 1'b0;
  logic vo_q[$];
  logic do_q[$];

  always @(negedge clk) begin
    if (wr_done === 1'b1) wr_done_cnt++;
`ifdef SERIAL_PARITY_EN
    if (perr === 1'b1) perr_cnt++;
`endif
    if (cap) begin
      vo_q.push_back(validOut);
      do_q.push_back(DataOut);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic a, input logic d);
    validIn = 1'b1;
    Address = a;
    DataIn  = d;
    tick();
    validIn = 1'b0;
  endtask

  task automatic stall(input int n);
    validIn = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic send_hdr(input logic w, input logic [11:0] a, input logic [1:0] len,
                          input int stall_at, output bit low_ok);
    logic [13:0] h;
    h = {a, len};
    wren = w;
    low_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == stall_at) stall(5);
      if (i > 0 && ready !== 1'b0) low_ok = 1'b0;
      put_bit(h[13-i], 1'b0);
    end
    wren = 1'b0;
  endtask

  // done_mode: 0 = no wr_done allowed, 1 = wr_done exactly 2 cycles after last bit, 2 = unchecked
  task automatic write_frame(input string tag, input logic [11:0] a, input logic [1:0] len,
                             input logic [7:0] d [4], input int hs, input int ds,
                             input int done_mode, input bit bad_par);
    bit low_ok;
    int base;
    int pos;
    wait_ready({tag, "_rdy"});
    base = wr_done_cnt;
    pos = -1;
    send_hdr(1'b1, a, len, hs, low_ok);
    for (int b = 0; b <= int'(len); b++) begin
      for (int j = 0; j < 8; j++) begin
        if (b == 0 && j == ds) stall(5);
        if (ready !== 1'b0) low_ok = 1'b0;
        put_bit(1'b0, d[b][7-j]);
      end
`ifdef SERIAL_PARITY_EN
      if (ready !== 1'b0) low_ok = 1'b0;
      put_bit(1'b0, (^d[b]) ^ bad_par);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      if (wr_done === 1'b1 && pos < 0) pos = k;
      tick();
    end
    check({tag, "_rdylow"}, 32'(low_ok), 32'd1);
    if (done_mode == 1) begin
      check({tag, "_wrdone_lat"}, 32'(pos), 32'd1);
      check({tag, "_wrdone_cnt"}, 32'(wr_done_cnt - base), 32'd1);
    end else if (done_mode == 0) begin
      check({tag, "_nodone"}, 32'(wr_done_cnt - base), 32'd0);
    end
  endtask

  task automatic read_frame(input string tag, input logic [11:0] a, input logic [1:0] len,
                            input logic [7:0] exp [4]);
    bit low_ok;
    bit shape_ok;
    bit par_ok;
    int idx;
    int ncyc;
    logic [7:0] w;
    wait_ready({tag, "_rdy"});
    send_hdr(1'b0, a, len, -1, low_ok);
    vo_q.delete();
    do_q.delete();
    cap = 1'b1;
    ncyc = 4 + (int'(len) + 1) * (BITS + 1);
    repeat (ncyc) tick();
    cap = 1'b0;
    check({tag, "_rdylow"}, 32'(low_ok), 32'd1);
    idx = 0;
    while (idx < vo_q.size() && vo_q[idx] !== 1'b1) idx++;
    check({tag, "_lat"}, 32'(idx), 32'd1);
    shape_ok = 1'b1;
    par_ok = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      w = 8'h00;
      for (int j = 0; j < BITS; j++) begin
        if (idx >= vo_q.size() || vo_q[idx] !== 1'b1) shape_ok = 1'b0;
        else if (j < 8) w = {w[6:0], do_q[idx]};
        else if (do_q[idx] !== ^w) par_ok = 1'b0;
        idx++;
      end
      check($sformatf("%s_beat%0d", tag, b), 32'(w), 32'(exp[b]));
      if (b < int'(len)) begin
        if (idx >= vo_q.size() || vo_q[idx] !== 1'b0) shape_ok = 1'b0;
        idx++;
      end
    end
    if (idx >= vo_q.size() || vo_q[idx] !== 1'b0) shape_ok = 1'b0;
    check({tag, "_shape"}, 32'(shape_ok), 32'd1);
`ifdef SERIAL_PARITY_EN
    check({tag, "_par"}, 32'(par_ok), 32'd1);
`endif
  endtask

  initial begin
    bit ok;
    int ones;
    int base;
    rst = 1'b1;
    validIn = 1'b0;
    wren = 1'b0;
    Address = 1'b0;
    DataIn = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_validOut", 32'(validOut), 32'd0);
    check("rst_DataOut", 32'(DataOut), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_rel_ready", 32'(ready), 32'd1);

    write_frame("w1", 12'h005, 2'd0, '{8'hA5, 8'h00, 8'h00, 8'h00}, -1, -1, 1, 1'b0);
    read_frame("r1", 12'h005, 2'd0, '{8'hA5, 8'h00, 8'h00, 8'h00});

    write_frame("wb", 12'h7FE, 2'd3, '{8'h11, 8'h22, 8'h33, 8'h44}, -1, -1, 1, 1'b0);
    read_frame("rb", 12'h7FE, 2'd3, '{8'h11, 8'h22, 8'h33, 8'h44});
    read_frame("rwrap", 12'h000, 2'd1, '{8'h33, 8'h44, 8'h00, 8'h00});

    write_frame("wmiss", 12'h805, 2'd0, '{8'hFF, 8'h00, 8'h00, 8'h00}, -1, -1, 0, 1'b0);
    read_frame("rmiss_keep", 12'h005, 2'd0, '{8'hA5, 8'h00, 8'h00, 8'h00});

    // Miss read: back to IDLE right after the header, no read data.
    wait_ready("rmiss_rdy");
    send_hdr(1'b0, 12'h805, 2'd1, -1, ok);
    check("rmiss_ready_back", 32'(ready), 32'd1);
    vo_q.delete();
    do_q.delete();
    cap = 1'b1;
    repeat (20) tick();
    cap = 1'b0;
    ones = 0;
    foreach (vo_q[i]) if (vo_q[i] !== 1'b0) ones++;
    check("rmiss_novalid", 32'(ones), 32'd0);

    write_frame("wstall", 12'h010, 2'd0, '{8'h3C, 8'h00, 8'h00, 8'h00}, 5, 3, 1, 1'b0);
    read_frame("rstall", 12'h010, 2'd0, '{8'h3C, 8'h00, 8'h00, 8'h00});

    // Reset in the middle of a write beat.
    write_frame("wclr", 12'h020, 2'd0, '{8'h00, 8'h00, 8'h00, 8'h00}, -1, -1, 1, 1'b0);
    wait_ready("wrst_rdy");
    send_hdr(1'b1, 12'h020, 2'd0, -1, ok);
    base = wr_done_cnt;
    for (int j = 0; j < 4; j++) put_bit(1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check("wrst_ready_in_rst", 32'(ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("wrst_ready_rel", 32'(ready), 32'd1);
    repeat (4) tick();
    check("wrst_nodone", 32'(wr_done_cnt - base), 32'd0);
    read_frame("rrst", 12'h020, 2'd0, '{8'h00, 8'h00, 8'h00, 8'h00});

`ifdef SERIAL_PARITY_EN
    write_frame("wpar_ok", 12'h030, 2'd0, '{8'h03, 8'h00, 8'h00, 8'h00}, -1, -1, 1, 1'b0);
    base = perr_cnt;
    write_frame("wpar_bad", 12'h030, 2'd0, '{8'h01, 8'h00, 8'h00, 8'h00}, -1, -1, 2, 1'b1);
    check("perr_cnt", 32'(perr_cnt - base), 32'd1);
    read_frame("rpar", 12'h030, 2'd0, '{8'h03, 8'h00, 8'h00, 8'h00});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
